// File: rtl/m3_run_sequencer.sv
// Run-control sequencer for the three-phase motor core: conditions raw buttons and sequences
// every start through align/ramp, and every stop or reversal through a timed brake.
module m3_run_sequencer #(
    parameter int unsigned DEB_CYC   = 20000,
    parameter int unsigned SPD_W     = 8,
    parameter int unsigned SPD_MIN   = 8,
    parameter int unsigned SPD_DEF   = 16,
    parameter int unsigned SPD_MAX   = 200,
    parameter int unsigned SPD_STEP  = 4,
    parameter int unsigned RAMP_DIV  = 1000,
    parameter int unsigned ALIGN_CYC = 50000,
    parameter int unsigned BRAKE_CYC = 100000,
    parameter int unsigned PWR_W     = 4,
    parameter int unsigned PWR_DEF   = 4
) (
    input  logic             clkI,
    input  logic             nRstI,
    input  logic             m3startI,
    input  logic             m3forceStopI,
    input  logic             m3invRotateI,
    input  logic             m3speedINCi,
    input  logic             m3speedDECi,
    input  logic             m3powerINCi,
    input  logic             m3powerDECi,
    output logic             runEnO,
    output logic             dirO,
    output logic [SPD_W-1:0] speedO,
    output logic [PWR_W-1:0] powerO,
    output logic [2:0]       stateO,
    output logic             busyO
);

    localparam int unsigned NUM_BTN = 7;
    localparam int unsigned DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned TMR_MAX = (ALIGN_CYC > BRAKE_CYC) ? ALIGN_CYC : BRAKE_CYC;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam int unsigned B_START = 0;
    localparam int unsigned B_FSTOP = 1;
    localparam int unsigned B_INV   = 2;
    localparam int unsigned B_SPINC = 3;
    localparam int unsigned B_SPDEC = 4;
    localparam int unsigned B_PWINC = 5;
    localparam int unsigned B_PWDEC = 6;

    localparam logic [SPD_W-1:0] SPD_STEP_V = SPD_W'(SPD_STEP);
    localparam logic [SPD_W-1:0] SPD_MIN_V  = SPD_W'(SPD_MIN);
    localparam logic [SPD_W-1:0] SPD_MAX_V  = SPD_W'(SPD_MAX);
    localparam logic [SPD_W:0]   SPD_STEP_X = (SPD_W + 1)'(SPD_STEP);
    localparam logic [SPD_W:0]   SPD_MIN_X  = (SPD_W + 1)'(SPD_MIN);
    localparam logic [SPD_W:0]   SPD_MAX_X  = (SPD_W + 1)'(SPD_MAX);
    localparam logic [PWR_W-1:0] PWR_TOP    = '1;
    localparam logic [PWR_W-1:0] PWR_ONE    = PWR_W'(1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAlign = 3'd1,
        StRamp  = 3'd2,
        StRun   = 3'd3,
        StBrake = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_prev;
    logic [NUM_BTN-1:0] pulse;

    assign raw_btn = {m3powerDECi, m3powerINCi, m3speedDECi, m3speedINCi,
                      m3invRotateI, m3forceStopI, m3startI};

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            sync1      <= '0;
            sync2      <= '0;
            level_prev <= '0;
        end else begin
            sync1      <= raw_btn;
            sync2      <= sync1;
            level_prev <= level;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             lvl;

        // Any sample that agrees with the accepted level restarts the stability count.
        always_ff @(posedge clkI or negedge nRstI) begin
            if (!nRstI) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYC - 1)) begin
                cnt <= '0;
                lvl <= sync2[g];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level[g] = lvl;
    end

    assign pulse = level & ~level_prev;

    logic p_start, p_fstop, p_inv, p_spd_inc, p_spd_dec, p_pwr_inc, p_pwr_dec, fs_level;

    assign p_start   = pulse[B_START];
    assign p_fstop   = pulse[B_FSTOP];
    assign p_inv     = pulse[B_INV];
    assign p_spd_inc = pulse[B_SPINC];
    assign p_spd_dec = pulse[B_SPDEC];
    assign p_pwr_inc = pulse[B_PWINC];
    assign p_pwr_dec = pulse[B_PWDEC];
    assign fs_level  = level[B_FSTOP];

    // ------------------------------------------------------------------
    // Speed target and power level
    // ------------------------------------------------------------------
    logic [SPD_W-1:0] target;
    logic [PWR_W-1:0] power;
    logic [SPD_W:0]   tgt_up;

    assign tgt_up = {1'b0, target} + SPD_STEP_X;

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            target <= SPD_W'(SPD_DEF);
            power  <= PWR_W'(PWR_DEF);
        end else begin
            if (p_spd_inc && !p_spd_dec) begin
                target <= (tgt_up > SPD_MAX_X) ? SPD_MAX_V : tgt_up[SPD_W-1:0];
            end else if (p_spd_dec && !p_spd_inc) begin
                target <= ({1'b0, target} < SPD_MIN_X + SPD_STEP_X) ? SPD_MIN_V
                                                                     : target - SPD_STEP_V;
            end
            if (p_pwr_inc && !p_pwr_dec && power != PWR_TOP) begin
                power <= power + PWR_ONE;
            end else if (p_pwr_dec && !p_pwr_inc && power > PWR_ONE) begin
                power <= power - PWR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run sequencer
    // ------------------------------------------------------------------
    state_e           state;
    logic [TMR_W-1:0] timer;
    logic [DIV_W-1:0] div_cnt;
    logic             restart;
    logic             run_en;
    logic             busy;
    logic             dir;
    logic [SPD_W-1:0] speed;
    logic [SPD_W-1:0] ramp_next;
    logic             go_brake;

    // One ramp step toward the target, clipped so it never overshoots.
    always_comb begin
        ramp_next = speed;
        if (target > speed) begin
            ramp_next = (target - speed <= SPD_STEP_V) ? target : speed + SPD_STEP_V;
        end else if (target < speed) begin
            ramp_next = (speed - target <= SPD_STEP_V) ? target : speed - SPD_STEP_V;
        end
    end

    assign go_brake = (state == StAlign || state == StRamp || state == StRun) &&
                      (p_fstop || p_inv);

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            state   <= StIdle;
            timer   <= '0;
            div_cnt <= '0;
            restart <= 1'b0;
            run_en  <= 1'b0;
            busy    <= 1'b0;
            dir     <= 1'b0;
            speed   <= '0;
        end else if (go_brake) begin
            // forceStop outranks invRotate, so it alone decides whether to restart.
            state   <= StBrake;
            run_en  <= 1'b0;
            speed   <= '0;
            timer   <= TMR_W'(BRAKE_CYC - 1);
            restart <= ~p_fstop;
        end else begin
            case (state)
                StIdle: begin
                    if (!p_fstop) begin
                        if (p_inv) begin
                            dir <= ~dir;
                        end else if (p_start && !fs_level) begin
                            state  <= StAlign;
                            run_en <= 1'b1;
                            busy   <= 1'b1;
                            speed  <= SPD_MIN_V;
                            timer  <= TMR_W'(ALIGN_CYC - 1);
                        end
                    end
                end
                StAlign: begin
                    if (timer == '0) begin
                        state   <= StRamp;
                        div_cnt <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                StRamp: begin
                    if (speed == target) begin
                        state <= StRun;
                    end else if (div_cnt == DIV_W'(RAMP_DIV - 1)) begin
                        div_cnt <= '0;
                        speed   <= ramp_next;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StRun: begin
                    if (target != speed) begin
                        state   <= StRamp;
                        div_cnt <= '0;
                    end
                end
                StBrake: begin
                    if (timer == '0) begin
                        restart <= 1'b0;
                        if (restart && !p_fstop) begin
                            dir    <= ~dir;
                            state  <= StAlign;
                            run_en <= 1'b1;
                            speed  <= SPD_MIN_V;
                            timer  <= TMR_W'(ALIGN_CYC - 1);
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                        if (p_fstop) begin
                            restart <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= StIdle;
                    run_en <= 1'b0;
                    busy   <= 1'b0;
                    speed  <= '0;
                end
            endcase
        end
    end

    assign runEnO = run_en;
    assign dirO   = dir;
    assign speedO = speed;
    assign powerO = power;
    assign stateO = state;
    assign busyO  = busy;

endmodule

// File: tb/tb_m3_run_sequencer.sv
// Bench for m3_run_sequencer: directed button sequences, a cycle model of the button/FSM rules
// checked every cycle, and literal expectations at the key points of each sequence.
module tb_m3_run_sequencer;

    localparam int DEB   = 4;
    localparam int RDIV  = 2;
    localparam int ALIGN = 10;
    localparam int BRAKE = 8;
    localparam int SMIN  = 8;
    localparam int SDEF  = 16;
    localparam int STEP  = 4;
    localparam int SMAX  = 40;
    localparam int PDEF  = 4;
    localparam int PMAX  = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] btn;
    logic       run_en_o, dir_o, busy_o;
    logic [7:0] speed_o;
    logic [3:0] power_o;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    m3_run_sequencer #(
        .DEB_CYC  (DEB),
        .SPD_W    (8),
        .SPD_MIN  (SMIN),
        .SPD_DEF  (SDEF),
        .SPD_MAX  (SMAX),
        .SPD_STEP (STEP),
        .RAMP_DIV (RDIV),
        .ALIGN_CYC(ALIGN),
        .BRAKE_CYC(BRAKE),
        .PWR_W    (4),
        .PWR_DEF  (PDEF)
    ) dut (
        .clkI        (clk),
        .nRstI       (rst_n),
        .m3startI    (btn[0]),
        .m3forceStopI(btn[1]),
        .m3invRotateI(btn[2]),
        .m3speedINCi (btn[3]),
        .m3speedDECi (btn[4]),
        .m3powerINCi (btn[5]),
        .m3powerDECi (btn[6]),
        .runEnO      (run_en_o),
        .dirO        (dir_o),
        .speedO      (speed_o),
        .powerO      (power_o),
        .stateO      (state_o),
        .busyO       (busy_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples per button; index 0 is the newest. A level is accepted once the DEB samples
    // visible through the two-stage synchronizer all disagree with it.
    bit hist [7][DEB+2];
    bit m_level [7];
    bit m_rise [7];
    int m_state, m_speed, m_target, m_power, m_dir, m_restart, m_left, m_age;

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            m_level[i] = 1'b0;
            m_rise[i]  = 1'b0;
            for (int j = 0; j < DEB + 2; j++) hist[i][j] = 1'b0;
        end
        m_state = 0; m_speed = 0; m_target = SDEF; m_power = PDEF;
        m_dir = 0; m_restart = 0; m_left = 0; m_age = 0;
    endtask

    task automatic enter_align();
        m_state = 1;
        m_speed = SMIN;
        m_left  = ALIGN;
    endtask

    task automatic model_step(input logic [6:0] raw);
        bit p [7];
        bit fs_lvl;
        bit all_diff;
        int nt, np;
        for (int i = 0; i < 7; i++) p[i] = m_rise[i];
        fs_lvl = m_level[1];
        nt = m_target;
        np = m_power;
        if (p[3] && !p[4]) nt = (m_target + STEP > SMAX) ? SMAX : m_target + STEP;
        if (p[4] && !p[3]) nt = (m_target - STEP < SMIN) ? SMIN : m_target - STEP;
        if (p[5] && !p[6] && m_power < PMAX) np = m_power + 1;
        if (p[6] && !p[5] && m_power > 1) np = m_power - 1;
        case (m_state)
            0: begin
                if (!p[1]) begin
                    if (p[2]) m_dir = 1 - m_dir;
                    else if (p[0] && !fs_lvl) enter_align();
                end
            end
            1, 2, 3: begin
                if (p[1] || p[2]) begin
                    m_state = 4; m_speed = 0; m_left = BRAKE;
                    m_restart = p[1] ? 0 : 1;
                end else if (m_state == 1) begin
                    m_left--;
                    if (m_left == 0) begin m_state = 2; m_age = 0; end
                end else if (m_state == 2) begin
                    if (m_speed == m_target) m_state = 3;
                    else begin
                        m_age++;
                        if (m_age % RDIV == 0) begin
                            if (m_target > m_speed)
                                m_speed = (m_speed + STEP > m_target) ? m_target : m_speed + STEP;
                            else
                                m_speed = (m_speed - STEP < m_target) ? m_target : m_speed - STEP;
                        end
                    end
                end else if (m_speed != m_target) begin
                    m_state = 2; m_age = 0;
                end
            end
            4: begin
                if (p[1]) m_restart = 0;
                m_left--;
                if (m_left == 0) begin
                    if (m_restart != 0) begin
                        m_dir = 1 - m_dir; m_restart = 0; enter_align();
                    end else m_state = 0;
                end
            end
            default: m_state = 0;
        endcase
        m_target = nt;
        m_power  = np;
        for (int i = 0; i < 7; i++) begin
            for (int j = DEB + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
            all_diff = 1'b1;
            for (int j = 2; j < DEB + 2; j++) if (hist[i][j] == m_level[i]) all_diff = 1'b0;
            m_rise[i] = all_diff && !m_level[i];
            if (all_diff) m_level[i] = !m_level[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step(btn);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m_run_en", int'(run_en_o), int'(m_state >= 1 && m_state <= 3));
                chk("m_dir",    int'(dir_o),    m_dir);
                chk("m_speed",  int'(speed_o),  m_speed);
                chk("m_power",  int'(power_o),  m_power);
                chk("m_state",  int'(state_o),  m_state);
                chk("m_busy",   int'(busy_o),   int'(m_state != 0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sequence did not end, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        cyc(6);
        btn[idx] = 1'b0;
        cyc(6);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_run_en"}, int'(run_en_o), 0);
        chk({tag, "_dir"},    int'(dir_o),    0);
        chk({tag, "_speed"},  int'(speed_o),  0);
        chk({tag, "_power"},  int'(power_o),  PDEF);
        chk({tag, "_state"},  int'(state_o),  0);
        chk({tag, "_busy"},   int'(busy_o),   0);
    endtask

    // Start press from a quiet IDLE with target 16: pulse acts on edge 7, align 10 cycles,
    // ramp 12 then 16 two cycles apart, RUN on edge 22.
    task automatic start_seq(input string tag);
        btn[0] = 1'b1;
        cyc(6);  chk({tag, "_idle_pre"},   int'(state_o),  0);
        cyc(1);  chk({tag, "_align"},      int'(state_o),  1);
                 chk({tag, "_align_en"},   int'(run_en_o), 1);
                 chk({tag, "_align_spd"},  int'(speed_o),  SMIN);
        cyc(3);  btn[0] = 1'b0;
        cyc(6);  chk({tag, "_align_end"},  int'(state_o),  1);
        cyc(1);  chk({tag, "_ramp"},       int'(state_o),  2);
                 chk({tag, "_ramp_8"},     int'(speed_o),  8);
        cyc(2);  chk({tag, "_ramp_12"},    int'(speed_o),  12);
        cyc(2);  chk({tag, "_ramp_16"},    int'(speed_o),  16);
        cyc(1);  chk({tag, "_run"},        int'(state_o),  3);
                 chk({tag, "_run_spd"},    int'(speed_o),  16);
        cyc(4);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        cyc(3);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        cyc(2);
        chk_reset_vals("rst_rel");

        // Bounce: never stable for DEB cycles, so no pulse.
        for (int i = 0; i < 5; i++) begin
            btn[0] = 1'b1; cyc(2);
            btn[0] = 1'b0; cyc(2);
        end
        cyc(10);
        chk("bounce_state", int'(state_o), 0);

        start_seq("s1");

        for (int i = 0; i < 12; i++) press(3);
        cyc(30);
        chk("spdinc_state", int'(state_o), 3);
        chk("spdinc_sat",   int'(speed_o), SMAX);

        for (int i = 0; i < 6; i++) press(4);
        cyc(20);
        chk("spddec_state", int'(state_o), 3);
        chk("spddec_spd",   int'(speed_o), 16);

        // Reverse in RUN.
        btn[2] = 1'b1; cyc(6); btn[2] = 1'b0;
        cyc(1);  chk("rev_brake",     int'(state_o),  4);
                 chk("rev_brake_en",  int'(run_en_o), 0);
                 chk("rev_brake_spd", int'(speed_o),  0);
                 chk("rev_dir_hold",  int'(dir_o),    0);
        cyc(7);  chk("rev_brake_end", int'(state_o),  4);
        cyc(1);  chk("rev_align",     int'(state_o),  1);
                 chk("rev_dir",       int'(dir_o),    1);
        cyc(30); chk("rev_run",       int'(state_o),  3);
                 chk("rev_run_spd",   int'(speed_o),  16);

        // forceStop + invRotate together during RAMP.
        btn[3] = 1'b1; cyc(2);
        btn[1] = 1'b1; btn[2] = 1'b1; cyc(4);
        btn[3] = 1'b0; cyc(2);
        chk("fsinv_in_ramp", int'(state_o), 2);
        cyc(1);
        chk("fsinv_brake", int'(state_o), 4);
        btn[1] = 1'b0; btn[2] = 1'b0;
        cyc(7);  chk("fsinv_brake_end", int'(state_o), 4);
        cyc(1);  chk("fsinv_idle",      int'(state_o), 0);
                 chk("fsinv_dir",       int'(dir_o),   1);

        // Start blocked while forceStop is held.
        btn[1] = 1'b1; cyc(10);
        btn[0] = 1'b1; cyc(6); btn[0] = 1'b0; cyc(6);
        chk("start_blocked", int'(state_o), 0);
        chk("start_blk_busy", int'(busy_o), 0);
        btn[1] = 1'b0; cyc(10);

        // invRotate in IDLE toggles direction only.
        btn[2] = 1'b1; cyc(6); btn[2] = 1'b0; cyc(1);
        chk("idle_inv_dir",   int'(dir_o),   0);
        chk("idle_inv_state", int'(state_o), 0);
        cyc(6);

        for (int i = 0; i < 20; i++) press(5);
        chk("pwr_max", int'(power_o), PMAX);
        for (int i = 0; i < 20; i++) press(6);
        chk("pwr_min", int'(power_o), 1);
        press(5);
        chk("pwr_2", int'(power_o), 2);
        btn[5] = 1'b1; btn[6] = 1'b1; cyc(6);
        btn[5] = 1'b0; btn[6] = 1'b0; cyc(6);
        chk("pwr_both", int'(power_o), 2);

        // Asynchronous reset in the middle of a ramp.
        btn[0] = 1'b1; cyc(10); btn[0] = 1'b0; cyc(8);
        chk("s6_ramp", int'(state_o), 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("s6_async");
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        start_seq("s6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
